csr_pipe_chain: RTL

// Parametrised multi-stage CSR sideband pipeline: carries CSR address, zimm, zimm/reg select,

---
 rtl/csr_pipe_chain.sv | 124 ++++++++++++
 1 files changed

// File: rtl/csr_pipe_chain.sv
// CSR sideband pipeline: ID -> STAGES registered stages with per-stage stall/flush,
// in-flight CSR write hazard detection, pending-write count and retire commit strobe.
module csr_pipe_chain #(
  parameter int STAGES = 3,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  localparam int CNT_W = $clog2(STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       csr_valid_id,
  input  logic [ADDR_W-1:0]          csr_addr_id,
  input  logic [DATA_W-1:0]          csr_zimm_id,
  input  logic                       csr_zimm_or_reg_id,
  input  logic                       csr_write_en_id,
  input  logic [STAGES-1:0]          stall,
  input  logic [STAGES-1:0]          flush,
  output logic [STAGES-1:0]          csr_valid_stg,
  output logic [STAGES*ADDR_W-1:0]   csr_addr_stg,
  output logic [STAGES*DATA_W-1:0]   csr_zimm_stg,
  output logic [STAGES-1:0]          csr_zsel_stg,
  output logic [STAGES-1:0]          csr_we_stg,
  output logic                       csr_raw_hazard,
  output logic [STAGES-1:0]          csr_raw_stage,
  output logic [CNT_W-1:0]           csr_wr_pending,
  output logic                       csr_commit
);

  logic [STAGES-1:0]             valid_q;
  logic [STAGES-1:0][ADDR_W-1:0] addr_q;
  logic [STAGES-1:0][DATA_W-1:0] zimm_q;
  logic [STAGES-1:0]             zsel_q;
  logic [STAGES-1:0]             we_q;

  logic [STAGES-1:0]             hold;
  logic [STAGES-1:0]             bubble;
  logic [STAGES-1:0]             up_valid;
  logic [STAGES-1:0][ADDR_W-1:0] up_addr;
  logic [STAGES-1:0][DATA_W-1:0] up_zimm;
  logic [STAGES-1:0]             up_zsel;
  logic [STAGES-1:0]             up_we;
  logic [STAGES-1:0]             match;

  // A stall anywhere downstream freezes every stage above it.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc     = acc | stall[k];
      hold[k] = acc;
    end
  end

  // Stage 0 is fed from ID with fields zeroed for invalid instructions.
  assign up_valid[0] = csr_valid_id;
  assign up_addr[0]  = csr_valid_id ? csr_addr_id : '0;
  assign up_zimm[0]  = csr_valid_id ? csr_zimm_id : '0;
  assign up_zsel[0]  = csr_valid_id & csr_zimm_or_reg_id;
  assign up_we[0]    = csr_valid_id & csr_write_en_id;
  assign bubble[0]   = 1'b0;

  for (genvar gk = 1; gk < STAGES; gk++) begin : g_link
    assign up_valid[gk] = valid_q[gk-1];
    assign up_addr[gk]  = addr_q[gk-1];
    assign up_zimm[gk]  = zimm_q[gk-1];
    assign up_zsel[gk]  = zsel_q[gk-1];
    assign up_we[gk]    = we_q[gk-1];
    assign bubble[gk]   = hold[gk-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      addr_q  <= '0;
      zimm_q  <= '0;
      zsel_q  <= '0;
      we_q    <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (!hold[k]) begin
          if (flush[k] || bubble[k]) begin
            valid_q[k] <= 1'b0;
            addr_q[k]  <= '0;
            zimm_q[k]  <= '0;
            zsel_q[k]  <= 1'b0;
            we_q[k]    <= 1'b0;
          end else begin
            valid_q[k] <= up_valid[k];
            addr_q[k]  <= up_addr[k];
            zimm_q[k]  <= up_zimm[k];
            zsel_q[k]  <= up_zsel[k];
            we_q[k]    <= up_we[k];
          end
        end
      end
    end
  end

  always_comb begin
    match = '0;
    for (int k = 0; k < STAGES; k++) begin
      match[k] = valid_q[k] & we_q[k] & (addr_q[k] == csr_addr_id) & csr_valid_id;
    end
  end

  always_comb begin
    csr_wr_pending = '0;
    for (int k = 0; k < STAGES; k++) begin
      csr_wr_pending = csr_wr_pending + CNT_W'(valid_q[k] & we_q[k]);
    end
  end

  assign csr_valid_stg  = valid_q;
  assign csr_addr_stg   = addr_q;
  assign csr_zimm_stg   = zimm_q;
  assign csr_zsel_stg   = zsel_q;
  assign csr_we_stg     = we_q & valid_q;
  assign csr_raw_hazard = |match;
  // Isolate the youngest matching stage.
  assign csr_raw_stage  = match & (~match + STAGES'(1));
  assign csr_commit     = valid_q[STAGES-1] & we_q[STAGES-1] & ~stall[STAGES-1];

endmodule
